// File: rtl/mul_arbiter_if.sv
// rtl/mul_arbiter_if.sv - requester, response and shared-multiplier signals of mul_arbiter
interface mul_arbiter_if #(
    parameter int NREQ = 4,
    parameter int N    = 4
);
    logic [NREQ-1:0]         req_vld;
    logic [NREQ-1:0][15:0]   req_a;
    logic [NREQ-1:0][N-1:0]  req_b;
    logic [NREQ-1:0]         req_rdy;
    logic [NREQ-1:0]         rsp_vld;
    logic [31:0]             rsp_c;
    logic                    rsp_err;
    logic [15:0]             mul_a;
    logic [N-1:0]            mul_b;
    logic                    mul_vld;
    logic [31:0]             mul_c;
    logic                    mul_result_vld;
    logic                    busy;

    modport slave (
        input  req_vld, req_a, req_b, mul_c, mul_result_vld,
        output req_rdy, rsp_vld, rsp_c, rsp_err, mul_a, mul_b, mul_vld, busy
    );

    modport master (
        output req_vld, req_a, req_b, mul_c, mul_result_vld,
        input  req_rdy, rsp_vld, rsp_c, rsp_err, mul_a, mul_b, mul_vld, busy
    );
endinterface

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin arbiter sharing one multiplier among NREQ requesters
module mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int N       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    mul_arbiter_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_gnt;
    logic [CW-1:0]   r_cnt;
    logic [15:0]     r_a;
    logic [N-1:0]    r_b;
    logic            r_mul_vld;
    logic [NREQ-1:0] r_rsp_vld;
    logic [31:0]     r_rsp_c;
    logic            r_rsp_err;

    logic            w_gnt_any;
    logic [PW-1:0]   w_gnt_idx;

    // First requester at or above r_ptr, wrapping to index 0.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (int'(r_ptr) + k) % NREQ;
            if (!w_gnt_any && bus.req_vld[PW'(j)]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = PW'(j);
            end
        end
    end

    assign bus.req_rdy = (r_state == S_IDLE && !rst && w_gnt_any) ?
                         (NREQ'(1) << w_gnt_idx) : '0;
    assign bus.rsp_vld = r_rsp_vld;
    assign bus.rsp_c   = r_rsp_c;
    assign bus.rsp_err = r_rsp_err;
    assign bus.mul_a   = r_a;
    assign bus.mul_b   = r_b;
    assign bus.mul_vld = r_mul_vld;
    assign bus.busy    = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_mul_vld <= 1'b0;
            r_rsp_vld <= '0;
            r_rsp_c   <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_rsp_vld <= '0;
                    r_rsp_err <= 1'b0;
                    if (w_gnt_any) begin
                        r_gnt     <= w_gnt_idx;
                        r_a       <= bus.req_a[w_gnt_idx];
                        r_b       <= bus.req_b[w_gnt_idx];
                        r_ptr     <= (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
                        r_cnt     <= '0;
                        r_mul_vld <= 1'b1;
                        r_state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // A result arriving on the timeout cycle still counts as success.
                    if (bus.mul_result_vld) begin
                        r_rsp_c   <= bus.mul_c;
                        r_rsp_err <= 1'b0;
                        r_rsp_vld <= NREQ'(1) << r_gnt;
                        r_mul_vld <= 1'b0;
                        r_state   <= S_RESP;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_rsp_c   <= '0;
                        r_rsp_err <= 1'b1;
                        r_rsp_vld <= NREQ'(1) << r_gnt;
                        r_mul_vld <= 1'b0;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_rsp_vld <= '0;
                    r_rsp_err <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - self-checking bench for mul_arbiter with a transaction-level model
module tb_mul_arbiter;
    localparam int NREQ    = 4;
    localparam int N       = 4;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_arbiter_if #(.NREQ(NREQ), .N(N)) bus ();

    mul_arbiter #(.NREQ(NREQ), .N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Multiplier: strobes the product mdelay+1 cycles after it first sees mul_vld.
    int mdelay = 5;
    int mcnt   = 0;
    bit spur_en = 1'b0;
    always @(posedge clk) begin
        #1;
        if (bus.mul_vld) begin
            mcnt++;
            bus.mul_result_vld = (mcnt == mdelay + 1);
            bus.mul_c = (mcnt == mdelay + 1) ? 32'(bus.mul_a) * 32'(bus.mul_b) : $urandom;
        end else begin
            mcnt = 0;
            bus.mul_result_vld = spur_en && ($urandom_range(0, 3) == 0);
            bus.mul_c = $urandom;
        end
    end

    // Reference model: one outstanding transaction, tracked by cycles since accept.
    int cyc = 0;
    bit pend = 1'b0;
    bit resolved = 1'b0;
    int g, k, ptr = 0, mv_cnt = 0;
    logic [15:0]   ma;
    logic [N-1:0]  mb;
    logic [31:0]   ec;
    logic          ee;
    int            acc_cyc[$], acc_g[$], rsp_cyc[$], rsp_g[$];
    logic [31:0]   rsp_cq[$];
    logic          rsp_eq[$];

    always @(negedge clk) begin
        bit found;
        int eg;
        logic [NREQ-1:0] erdy;
        cyc++;
        if (rst) begin
            chk("rst_rdy", bus.req_rdy, 0);
            chk("rst_rsp_vld", bus.rsp_vld, 0);
            chk("rst_rsp_c", bus.rsp_c, 0);
            chk("rst_rsp_err", bus.rsp_err, 0);
            chk("rst_mul_vld", bus.mul_vld, 0);
            chk("rst_mul_a", bus.mul_a, 0);
            chk("rst_mul_b", bus.mul_b, 0);
            chk("rst_busy", bus.busy, 0);
            pend = 0; resolved = 0; ptr = 0;
        end else if (!pend) begin
            found = 0; eg = 0;
            for (int i = 0; i < NREQ; i++)
                if (!found && bus.req_vld[(ptr + i) % NREQ]) begin
                    found = 1; eg = (ptr + i) % NREQ;
                end
            erdy = found ? (NREQ'(1) << eg) : '0;
            chk("idle_rdy", bus.req_rdy, erdy);
            chk("idle_busy", bus.busy, 0);
            chk("idle_rsp_vld", bus.rsp_vld, 0);
            chk("idle_mul_vld", bus.mul_vld, 0);
            if (found) begin
                pend = 1; resolved = 0; k = 0; g = eg;
                ma = bus.req_a[eg]; mb = bus.req_b[eg];
                ptr = (eg + 1) % NREQ;
                acc_cyc.push_back(cyc); acc_g.push_back(eg);
            end
        end else if (!resolved) begin
            k++;
            if (bus.mul_vld) mv_cnt++;
            chk("busy_busy", bus.busy, 1);
            chk("busy_rdy", bus.req_rdy, 0);
            chk("busy_rsp_vld", bus.rsp_vld, 0);
            chk("busy_mul_vld", bus.mul_vld, 1);
            chk("busy_mul_a", bus.mul_a, ma);
            chk("busy_mul_b", bus.mul_b, mb);
            if (bus.mul_result_vld) begin
                resolved = 1; ec = bus.mul_c; ee = 0;
            end else if (k == TIMEOUT) begin
                resolved = 1; ec = 0; ee = 1;
            end
        end else begin
            chk("resp_vld", bus.rsp_vld, NREQ'(1) << g);
            chk("resp_c", bus.rsp_c, ec);
            chk("resp_err", bus.rsp_err, ee);
            chk("resp_busy", bus.busy, 1);
            chk("resp_mul_vld", bus.mul_vld, 0);
            chk("resp_rdy", bus.req_rdy, 0);
            rsp_cyc.push_back(cyc); rsp_g.push_back(g);
            rsp_cq.push_back(bus.rsp_c); rsp_eq.push_back(bus.rsp_err);
            pend = 0;
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        acc_cyc.delete(); acc_g.delete(); rsp_cyc.delete(); rsp_g.delete();
        rsp_cq.delete(); rsp_eq.delete(); mv_cnt = 0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        bus.req_vld = '0;
        while ((pend || bus.busy) && t < 100) begin
            cycles(1);
            t++;
        end
        chk("drain_bound", t < 100, 1);
    endtask

    task automatic single(input int idx, input logic [15:0] a, input logic [N-1:0] b);
        bus.req_a[idx] = a;
        bus.req_b[idx] = b;
        bus.req_vld = NREQ'(1) << idx;
        #1;
        chk("single_rdy", bus.req_rdy, NREQ'(1) << idx);
        cycles(1);
        bus.req_vld = '0;
    endtask

    initial begin
        rst = 1'b1;
        bus.req_vld = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        cycles(3);
        rst = 1'b0;
        cycles(1);

        // Single request, product 15 seven cycles after accept.
        clear_logs(); mdelay = 5;
        single(0, 16'd3, 4'd5);
        cycles(10);
        chk("t1_naccept", acc_g.size(), 1);
        chk("t1_nrsp", rsp_g.size(), 1);
        if (rsp_g.size() == 1 && acc_g.size() == 1) begin
            chk("t1_g", rsp_g[0], 0);
            chk("t1_lat", rsp_cyc[0] - acc_cyc[0], 7);
            chk("t1_c", rsp_cq[0], 32'd15);
            chk("t1_err", rsp_eq[0], 0);
        end
        chk("t1_mulvld_cycles", mv_cnt, 6);
        drain();

        // All requesters held from reset: round-robin every 8 cycles.
        rst = 1'b1; clear_logs();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i] = 16'(i + 2);
            bus.req_b[i] = N'(i + 1);
        end
        bus.req_vld = '1;
        cycles(2);
        rst = 1'b0;
        cycles(42);
        bus.req_vld = '0;
        chk("t2_naccept_ge5", acc_g.size() >= 5, 1);
        if (acc_g.size() >= 5) begin
            chk("t2_g0", acc_g[0], 0); chk("t2_g1", acc_g[1], 1);
            chk("t2_g2", acc_g[2], 2); chk("t2_g3", acc_g[3], 3);
            chk("t2_g4", acc_g[4], 0);
            for (int i = 0; i < 4; i++) chk("t2_spacing", acc_cyc[i+1] - acc_cyc[i], 8);
        end
        drain();

        // Multiplier never answers: timeout 17 cycles after accept.
        clear_logs(); mdelay = 1000;
        single(2, 16'h00AB, 4'h3);
        cycles(20);
        chk("t3_nrsp", rsp_g.size(), 1);
        if (rsp_g.size() == 1) begin
            chk("t3_g", rsp_g[0], 2);
            chk("t3_lat", rsp_cyc[0] - acc_cyc[0], 17);
            chk("t3_c", rsp_cq[0], 0);
            chk("t3_err", rsp_eq[0], 1);
        end
        chk("t3_mul_vld_after", bus.mul_vld, 0);
        drain();

        // Result on the timeout cycle wins.
        clear_logs(); mdelay = 15;
        single(3, 16'h1234, 4'h7);
        cycles(20);
        chk("t4_nrsp", rsp_g.size(), 1);
        if (rsp_g.size() == 1) begin
            chk("t4_lat", rsp_cyc[0] - acc_cyc[0], 17);
            chk("t4_c", rsp_cq[0], 32'h00007F6C);
            chk("t4_err", rsp_eq[0], 0);
        end
        drain();

        // Reset three cycles after accept aborts; first grant afterwards uses pointer 0.
        clear_logs(); mdelay = 5;
        single(1, 16'h0042, 4'h2);
        cycles(2);
        rst = 1'b1;
        #1;
        chk("t5_busy", bus.busy, 0);
        chk("t5_mul_vld", bus.mul_vld, 0);
        chk("t5_mul_a", bus.mul_a, 0);
        chk("t5_rdy", bus.req_rdy, 0);
        bus.req_vld = 4'b0101;
        cycles(2);
        chk("t5_no_rsp", rsp_g.size(), 0);
        rst = 1'b0;
        #1;
        chk("t5_first_rdy", bus.req_rdy, 4'b0001);
        cycles(1);
        bus.req_vld = '0;
        chk("t5_first_g", acc_g[acc_g.size()-1], 0);
        drain();

        // Operand changes during BUSY are ignored.
        clear_logs(); mdelay = 5;
        single(1, 16'hFFFF, 4'hF);
        bus.req_a[1] = 16'h0000;
        bus.req_b[1] = 4'h0;
        bus.req_vld = '1;
        cycles(3);
        chk("t6_mul_a", bus.mul_a, 16'hFFFF);
        chk("t6_mul_b", bus.mul_b, 4'hF);
        bus.req_vld = '0;
        cycles(8);
        chk("t6_nrsp_ge1", rsp_g.size() >= 1, 1);
        if (rsp_g.size() >= 1) chk("t6_c", rsp_cq[0], 32'h000EFFF1);
        drain();

        // Randomized traffic with spurious strobes and occasional resets.
        spur_en = 1'b1;
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            bus.req_vld = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom_range(0, (1 << NREQ) - 1));
            for (int r = 0; r < NREQ; r++) begin
                bus.req_a[r] = 16'($urandom);
                bus.req_b[r] = N'($urandom);
            end
            if (!bus.mul_vld) mdelay = $urandom_range(0, 18);
            cycles(1);
        end
        rst = 1'b0;
        drain();
        spur_en = 1'b0;
        cycles(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of requesters; N, default 4, width of operand b; TIMEOUT, default 16, maximum BUSY cycles before abort.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 req_vld  in  NREQ  per-requester operation request.
REQ-005 req_a  in  NREQ x 16  per-requester multiplicand.
REQ-006 req_b  in  NREQ x N  per-requester multiplier operand.
REQ-007 req_rdy  out  NREQ  one-hot accept; a transfer occurs when req_vld[i] and req_rdy[i] are both high.
REQ-008 rsp_vld  out  NREQ  one-hot, single-cycle response strobe to the owning requester.
REQ-009 rsp_c  out  32  product for the strobed requester.
REQ-010 rsp_err  out  1  high with rsp_vld when the operation timed out.
REQ-011 mul_a  out  16  operand a driven to the shared multiplier.
REQ-012 mul_b  out  N  operand b driven to the shared multiplier.
REQ-013 mul_vld  out  1  multiplier valid, registered.
REQ-014 mul_c  in  32  multiplier result.
REQ-015 mul_result_vld  in  1  multiplier one-cycle result strobe.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, BUSY and RESP.
REQ-018 In IDLE, req_rdy SHALL be combinational: one-hot on the first asserted req_vld found searching upward, with wrap, from index rr_ptr; it SHALL be all-zero when no req_vld is high or when the state is not IDLE.
REQ-019 On acceptance of requester g, the block SHALL latch g, req_a[g] and req_b[g], set rr_ptr to (g+1) mod NREQ, enter BUSY, and set mul_vld to 1 on the same edge.
REQ-020 mul_a and mul_b SHALL be driven from the latched operands and SHALL stay stable throughout BUSY.
REQ-021 In BUSY, mul_vld SHALL stay high continuously until mul_result_vld is sampled high.
REQ-022 When mul_result_vld is sampled high in BUSY, the block SHALL capture mul_c into rsp_c, clear mul_vld and enter RESP on the same edge.
REQ-023 RESP SHALL last exactly one cycle, with rsp_vld[g]=1, rsp_err as determined, and rsp_vld low for all other indices; the state SHALL then return to IDLE.
REQ-024 Responses SHALL have no backpressure: requesters SHALL take the response in the RESP cycle.
REQ-025 The BUSY cycle counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-026 If the counter reaches TIMEOUT-1 without mul_result_vld, the block SHALL enter RESP with rsp_err=1 and rsp_c=0, and SHALL clear mul_vld.
REQ-027 If mul_result_vld and the timeout occur in the same cycle, the result SHALL win and rsp_err SHALL be 0.
REQ-028 mul_result_vld SHALL be ignored in IDLE and in RESP.
REQ-029 req_vld changes in BUSY or RESP SHALL have no effect, and the latched operands SHALL stay unchanged.
REQ-030 Latency from accept edge to rsp_vld, given a multiplier that raises mul_result_vld N+1 cycles after first sampling mul_vld, SHALL be N+3 cycles.
REQ-031 The minimum interval between two accepts SHALL be N+4 cycles.
REQ-032 rr_ptr SHALL wrap from NREQ-1 to 0.
REQ-033 A requester whose req_vld stays high SHALL be granted within NREQ operations.

Reset
REQ-034 While rst is high, asynchronously: state=IDLE, rr_ptr=0, counter=0, mul_vld=0, mul_a=0, mul_b=0, rsp_vld=0, rsp_c=0, rsp_err=0, busy=0; req_rdy SHALL also be held at 0.
REQ-035 Reset asserted mid-operation SHALL abort the operation with no response issued; after release, the first grant SHALL use rr_ptr=0.

Verification
REQ-036 The bench SHALL cover: single request, N=4, req_vld[0], a=3, b=5 -> req_rdy[0] at T0, mul_vld high T1..T6, rsp_vld[0] with rsp_c=15 and rsp_err=0 at T7.
REQ-037 The bench SHALL cover: all four req_vld held high from reset -> grant order 0,1,2,3,0, with accepts spaced exactly 8 cycles apart.
REQ-038 The bench SHALL cover: multiplier model never strobes, TIMEOUT=16 -> rsp_vld[g] with rsp_err=1 and rsp_c=0 exactly 17 cycles after accept, then mul_vld=0.
REQ-039 The bench SHALL cover: mul_result_vld strobed in the same cycle the counter hits TIMEOUT-1 -> rsp_err=0 and rsp_c equal to mul_c.
REQ-040 The bench SHALL cover: rst pulsed 3 cycles after accept -> all outputs zero immediately; after release, req_vld[2] and req_vld[0] both high -> requester 0 granted first.
REQ-041 The bench SHALL cover: req_a changed during BUSY (a=0xFFFF, b=0xF) -> mul_a/mul_b unchanged and rsp_c=0x000EFFF1.
